// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system ID and timestamp words
// and reports whether they agree with the values this hardware was built with.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd1,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1409239941,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_LAT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS  = 3'd3;
    localparam logic [2:0] S_LAT_TS = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LAST  = 3'(READ_LATENCY);

    logic [2:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic        auto_q, auto_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        match_q, match_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic take_id;
    logic take_ts;
    logic to_hit;
    logic finish;
    logic got_id;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        auto_d     = auto_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        match_d    = match_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        take_id    = 1'b0;
        take_ts    = 1'b0;
        to_hit     = 1'b0;
        finish     = 1'b0;
        got_id     = (state_q == S_RD_TS) || (state_q == S_LAT_TS);

        unique case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d    = S_RD_ID;
                    auto_d     = 1'b0;
                    wait_cnt_d = 16'd0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    match_d    = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (avm_waitrequest) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        to_hit = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else if (READ_LATENCY == 0) begin
                    take_id = (state_q == S_RD_ID);
                    take_ts = (state_q == S_RD_TS);
                end else begin
                    state_d   = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                    lat_cnt_d = 3'd1;
                end
            end
            S_LAT_ID, S_LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    take_id = (state_q == S_LAT_ID);
                    take_ts = (state_q == S_LAT_TS);
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_id) begin
            id_value_d = avm_readdata;
            got_id     = 1'b1;
            if (CHECK_TIMESTAMP) begin
                state_d    = S_RD_TS;
                wait_cnt_d = 16'd0;
            end else begin
                finish = 1'b1;
            end
        end
        if (take_ts) begin
            ts_value_d = avm_readdata;
            finish     = 1'b1;
        end
        if (to_hit) begin
            timeout_d = 1'b1;
            finish    = 1'b1;
        end

        // Status is judged only on words captured during this check.
        if (finish) begin
            state_d = S_DONE;
            id_ok_d = got_id && (id_value_d == EXPECTED_ID);
            ts_ok_d = !CHECK_TIMESTAMP ||
                      (take_ts && (ts_value_d == EXPECTED_TIMESTAMP));
            match_d = id_ok_d && ts_ok_d && !to_hit;
        end
    end

    always_comb begin
        avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        avm_address_d = (state_d == S_RD_TS);
        busy_d        = (state_d == S_RD_ID) || (state_d == S_LAT_ID) ||
                        (state_d == S_RD_TS) || (state_d == S_LAT_TS);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 16'd0;
            lat_cnt_q     <= 3'd0;
            auto_q        <= AUTO_START;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            match_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            auto_q        <= auto_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            match_q       <= match_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign match       = match_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a zero-wait latency-0 instance (a) and a
// stalled, latency-2, short-timeout instance (b), each with its own slave model.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd1;
    localparam logic [31:0] EXP_TS = 32'd1409239941;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        a_addr, a_read, a_busy, a_done;
    logic        a_id_ok, a_ts_ok, a_match, a_timeout;
    logic [31:0] a_rdata, a_id_value, a_ts_value;
    logic        b_addr, b_read, b_wait, b_busy, b_done;
    logic        b_id_ok, b_ts_ok, b_match, b_timeout;
    logic [31:0] b_rdata, b_id_value, b_ts_value;

    logic [31:0] mem_a [2];
    logic [31:0] mem_b [2];
    logic [31:0] b_s1, b_s2;
    int b_wait_n = 0;
    bit b_stuck = 1'b0;
    int b_stall = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int viol_b = 0;
    logic prev_stall = 1'b0;
    logic prev_addr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sysid_checker u_a (
        .clock(clock), .reset(reset), .start(start_a),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_waitrequest(1'b0), .avm_readdata(a_rdata),
        .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
        .match(a_match), .timeout(a_timeout),
        .id_value(a_id_value), .ts_value(a_ts_value)
    );

    sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8)) u_b (
        .clock(clock), .reset(reset), .start(start_b),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_waitrequest(b_wait), .avm_readdata(b_rdata),
        .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
        .match(b_match), .timeout(b_timeout),
        .id_value(b_id_value), .ts_value(b_ts_value)
    );

    assign a_rdata = a_read ? mem_a[a_addr] : 32'hDEAD_BEEF;
    assign b_wait = b_read && (b_stuck || (b_stall < b_wait_n));
    assign b_rdata = b_s2;

    // Slave b returns data two edges after acceptance; junk otherwise.
    always @(posedge clock) begin
        b_stall <= (b_read && b_wait) ? b_stall + 1 : 0;
        b_s1 <= (b_read && !b_wait) ? mem_b[b_addr] : $urandom;
        b_s2 <= b_s1;
        cyc <= cyc + 1;
        if (a_done) done_cnt_a <= done_cnt_a + 1;
        if (b_done) done_cnt_b <= done_cnt_b + 1;
        prev_stall <= b_read && b_wait;
        prev_addr <= b_addr;
        if (prev_stall && !b_done && (!b_read || b_addr != prev_addr))
            viol_b <= viol_b + 1;
    end

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int exp_edges(int reads, int w, int lat);
        return reads * (1 + w + lat);
    endfunction

    task automatic pulse_a(output int t0);
        @(negedge clock);
        start_a = 1'b1;
        t0 = cyc + 1;
        @(negedge clock);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(output int t0);
        @(negedge clock);
        start_b = 1'b1;
        t0 = cyc + 1;
        @(negedge clock);
        start_b = 1'b0;
    endtask

    task automatic wait_a(input int lim, output int c, output bit ok);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clock);
            if (a_done) begin ok = 1'b1; c = cyc; end
        end
    endtask

    task automatic wait_b(input int lim, output int c, output bit ok);
        ok = 1'b0;
        c = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clock);
            if (b_done) begin ok = 1'b1; c = cyc; end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_match,
             a_timeout, a_id_value, a_ts_value} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs not zero id=%h ts=%h rd=%b",
                     a_id_value, a_ts_value, a_read);
        end
        n_checks++;
        if ({b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_match,
             b_timeout, b_id_value, b_ts_value} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs not zero id=%h ts=%h rd=%b",
                     b_id_value, b_ts_value, b_read);
        end
    endtask

    task automatic test_auto_start;
        int t0, c;
        bit ok;
        @(negedge clock);
        reset = 1'b0;
        t0 = cyc + 1;
        wait_a(20, c, ok);
        n_checks++;
        if (!ok || c - t0 != exp_edges(2, 0, 0)) begin
            n_fail++;
            $display("FAIL auto_a_lat: got %0d want %0d ok=%b", c - t0,
                     exp_edges(2, 0, 0), ok);
        end
        n_checks++;
        if ({a_id_ok, a_ts_ok, a_match, a_timeout, a_id_value, a_ts_value}
            !== {4'b1110, EXP_ID, EXP_TS}) begin
            n_fail++;
            $display("FAIL auto_a_status: got %b%b%b%b %h %h want 1110",
                     a_id_ok, a_ts_ok, a_match, a_timeout, a_id_value, a_ts_value);
        end
        wait_b(20, c, ok);
        n_checks++;
        if (!ok || c - t0 != exp_edges(2, 0, 2)) begin
            n_fail++;
            $display("FAIL auto_b_lat: got %0d want %0d ok=%b", c - t0,
                     exp_edges(2, 0, 2), ok);
        end
        n_checks++;
        if ({b_match, b_timeout, b_id_value, b_ts_value}
            !== {2'b10, EXP_ID, EXP_TS}) begin
            n_fail++;
            $display("FAIL auto_b_status: got m=%b t=%b %h %h",
                     b_match, b_timeout, b_id_value, b_ts_value);
        end
        repeat (6) @(negedge clock);
        n_checks++;
        if (done_cnt_a != 1 || done_cnt_b != 1) begin
            n_fail++;
            $display("FAIL auto_once: got a=%0d b=%0d want 1 1",
                     done_cnt_a, done_cnt_b);
        end
    endtask

    task automatic test_mismatch;
        int t0, c;
        bit ok, eid, ets;
        mem_a[1] = 32'h5400_0000;
        pulse_a(t0);
        wait_a(10, c, ok);
        n_checks++;
        if (!ok || c - t0 != 2) begin
            n_fail++;
            $display("FAIL mism_lat: got %0d want 2 ok=%b", c - t0, ok);
        end
        n_checks++;
        if ({a_id_ok, a_ts_ok, a_match, a_ts_value} !== {3'b100, 32'h5400_0000}) begin
            n_fail++;
            $display("FAIL mism_status: got %b%b%b ts=%h want 100 54000000",
                     a_id_ok, a_ts_ok, a_match, a_ts_value);
        end
        for (int i = 0; i < 8; i++) begin
            mem_a[0] = $urandom_range(0, 1) ? EXP_ID : $urandom;
            mem_a[1] = $urandom_range(0, 1) ? EXP_TS : $urandom;
            eid = (mem_a[0] == EXP_ID);
            ets = (mem_a[1] == EXP_TS);
            pulse_a(t0);
            wait_a(10, c, ok);
            n_checks++;
            if (!ok || c - t0 != 2 || {a_id_ok, a_ts_ok, a_match, a_timeout}
                != {eid, ets, eid & ets, 1'b0} || a_id_value != mem_a[0]
                || a_ts_value != mem_a[1]) begin
                n_fail++;
                $display("FAIL rand_a[%0d]: got lat=%0d %b%b%b%b %h %h want %b%b %h %h",
                         i, c - t0, a_id_ok, a_ts_ok, a_match, a_timeout,
                         a_id_value, a_ts_value, eid, ets, mem_a[0], mem_a[1]);
            end
        end
        mem_a[0] = EXP_ID;
        mem_a[1] = EXP_TS;
    endtask

    task automatic test_wait_latency;
        int t0, c, w;
        bit ok, eid, ets;
        int v0;
        v0 = viol_b;
        b_wait_n = 4;
        pulse_b(t0);
        wait_b(60, c, ok);
        n_checks++;
        if (!ok || c - t0 != exp_edges(2, 4, 2)) begin
            n_fail++;
            $display("FAIL wait_lat: got %0d want %0d ok=%b", c - t0,
                     exp_edges(2, 4, 2), ok);
        end
        n_checks++;
        if ({b_match, b_timeout, b_id_value, b_ts_value}
            !== {2'b10, EXP_ID, EXP_TS}) begin
            n_fail++;
            $display("FAIL wait_status: got m=%b t=%b %h %h",
                     b_match, b_timeout, b_id_value, b_ts_value);
        end
        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(0, 5);
            b_wait_n = w;
            mem_b[0] = $urandom_range(0, 1) ? EXP_ID : $urandom;
            mem_b[1] = $urandom_range(0, 1) ? EXP_TS : $urandom;
            eid = (mem_b[0] == EXP_ID);
            ets = (mem_b[1] == EXP_TS);
            pulse_b(t0);
            wait_b(60, c, ok);
            n_checks++;
            if (!ok || c - t0 != exp_edges(2, w, 2) || {b_id_ok, b_ts_ok,
                b_match, b_timeout} != {eid, ets, eid & ets, 1'b0}
                || b_id_value != mem_b[0] || b_ts_value != mem_b[1]) begin
                n_fail++;
                $display("FAIL rand_b[%0d]: w=%0d got lat=%0d %b%b%b%b %h %h want %h %h",
                         i, w, c - t0, b_id_ok, b_ts_ok, b_match, b_timeout,
                         b_id_value, b_ts_value, mem_b[0], mem_b[1]);
            end
        end
        n_checks++;
        if (viol_b != v0) begin
            n_fail++;
            $display("FAIL addr_stable: got %0d changes want 0", viol_b - v0);
        end
        mem_b[0] = EXP_ID;
        mem_b[1] = EXP_TS;
        b_wait_n = 0;
    endtask

    task automatic test_timeout;
        int t0, c;
        bit ok;
        b_stuck = 1'b1;
        pulse_b(t0);
        wait_b(40, c, ok);
        n_checks++;
        if (!ok || c - t0 != 8) begin
            n_fail++;
            $display("FAIL tmo_lat: got %0d want 8 ok=%b", c - t0, ok);
        end
        n_checks++;
        if ({b_read, b_busy, b_timeout, b_match, b_id_ok} !== 5'b00100) begin
            n_fail++;
            $display("FAIL tmo_status: got rd=%b busy=%b t=%b m=%b id_ok=%b want 00100",
                     b_read, b_busy, b_timeout, b_match, b_id_ok);
        end
        b_stuck = 1'b0;
    endtask

    task automatic test_start_while_busy;
        int t0, c, d0;
        bit ok;
        d0 = done_cnt_a;
        pulse_a(t0);
        @(negedge clock);
        n_checks++;
        if ({a_read, a_addr, a_busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL rd_ts_state: got rd=%b addr=%b busy=%b want 111",
                     a_read, a_addr, a_busy);
        end
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        n_checks++;
        if ({a_done, a_busy, a_match} !== 3'b101) begin
            n_fail++;
            $display("FAIL busy_done: got done=%b busy=%b m=%b want 101",
                     a_done, a_busy, a_match);
        end
        repeat (6) @(negedge clock);
        n_checks++;
        if (done_cnt_a != d0 + 1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop: got %0d dones busy=%b want %0d 0",
                     done_cnt_a - d0, a_busy, 1);
        end
        pulse_a(t0);
        wait_a(10, c, ok);
        n_checks++;
        if (!ok || c - t0 != 2 || a_match !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_restart: got lat=%0d m=%b want 2 1", c - t0, a_match);
        end
    endtask

    task automatic test_reset_mid;
        int t0, c;
        bit ok;
        pulse_a(t0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_match,
             a_timeout, a_id_value, a_ts_value} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rd=%b busy=%b id=%h want all 0",
                     a_read, a_busy, a_id_value);
        end
        @(negedge clock);
        reset = 1'b0;
        t0 = cyc + 1;
        wait_a(20, c, ok);
        n_checks++;
        if (!ok || c - t0 != 2 || {a_match, a_id_value, a_ts_value}
            !== {1'b1, EXP_ID, EXP_TS}) begin
            n_fail++;
            $display("FAIL reset_rerun: got lat=%0d m=%b %h %h ok=%b",
                     c - t0, a_match, a_id_value, a_ts_value, ok);
        end
        repeat (10) @(negedge clock);
    endtask

    initial begin
        mem_a[0] = EXP_ID;
        mem_a[1] = EXP_TS;
        mem_b[0] = EXP_ID;
        mem_b[1] = EXP_TS;
        repeat (3) @(negedge clock);
        test_reset();
        test_auto_start();
        test_mismatch();
        test_wait_latency();
        test_timeout();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
